// File: rtl/sdp_ram_arb_pkg.sv
// sdp_ram_arb_pkg: shared width helper and response type for the shared-RAM arbiter.
package sdp_ram_arb_pkg;
    localparam int MAX_ID_W   = 4;
    localparam int MAX_DATA_W = 64;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sized for the largest supported configuration; narrower users zero-extend.
    typedef struct packed {
        logic                  valid;
        logic [MAX_ID_W-1:0]   id;
        logic [MAX_DATA_W-1:0] data;
    } rsp_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; search starts at the pointer, pointer moves past the winner.
module rr_arbiter
    import sdp_ram_arb_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = id_width(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_grant_idx
);
    logic [W-1:0] ptr;
    logic [N-1:0] req;
    logic         found;
    int           j;

    assign req = i_rst ? '0 : i_req;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        j           = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            j = (j >= N) ? j - N : j;
            if (!found && req[j]) begin
                found       = 1'b1;
                o_grant[j]  = 1'b1;
                o_grant_idx = W'(j);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            ptr <= '0;
        else if (found)
            ptr <= (o_grant_idx == W'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
endmodule

// File: rtl/sdp_block_ram.sv
// sdp_block_ram: simple dual-port RAM, registered read-first output, no reset on contents.
module sdp_block_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_we)
            mem[i_waddr] <= i_wdata;
        if (i_re)
            o_rdata <= mem[i_raddr];
    end
endmodule

// File: rtl/sdp_ram_arbiter.sv
// sdp_ram_arbiter: shares one SDP block RAM among NUM_REQ requesters with independent
// round-robin write/read arbitration and id-tagged read responses one cycle after grant.
module sdp_ram_arbiter
    import sdp_ram_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_WIDTH = 10,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_wr_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wr_data,
    output logic [NUM_REQ-1:0]            o_wr_ready,
    input  logic [NUM_REQ-1:0]            i_rd_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_REQ-1:0]            o_rd_ready,
    output logic                          o_rsp_valid,
    output logic [ID_W-1:0]               o_rsp_id,
    output logic [DATA_WIDTH-1:0]         o_rsp_data
);
    logic [ID_W-1:0]       wr_idx, rd_idx;
    logic                  we, re;
    logic [ADDR_WIDTH-1:0] waddr, raddr;
    logic [DATA_WIDTH-1:0] wdata;

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_wr_valid),
        .o_grant     (o_wr_ready),
        .o_grant_idx (wr_idx)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_rd_valid),
        .o_grant     (o_rd_ready),
        .o_grant_idx (rd_idx)
    );

    assign we    = |o_wr_ready;
    assign re    = |o_rd_ready;
    assign waddr = i_wr_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata = i_wr_data[wr_idx*DATA_WIDTH +: DATA_WIDTH];
    assign raddr = i_rd_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];

    // Without a read grant the RAM output register holds, matching a held read address.
    sdp_block_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .i_clk   (i_clk),
        .i_we    (we),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_re    (re),
        .i_raddr (raddr),
        .o_rdata (o_rsp_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
        end else begin
            o_rsp_valid <= re;
            if (re)
                o_rsp_id <= rd_idx;
        end
    end
endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// tb_sdp_ram_arbiter: directed stimulus, cycle model of grants/RAM/responses plus literal pins.
module tb_sdp_ram_arbiter;
    import sdp_ram_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    wr_valid, wr_ready, rd_valid, rd_ready;
    logic [N*AW-1:0] wr_addr, rd_addr;
    logic [N*DW-1:0] wr_data;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    sdp_ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_valid  (wr_valid),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_wr_ready  (wr_ready),
        .i_rd_valid  (rd_valid),
        .i_rd_addr   (rd_addr),
        .o_rd_ready  (rd_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: pointers as integers, memory as a sparse map of known contents.
    int               m_wptr = 0;
    int               m_rptr = 0;
    rsp_t             m_rsp  = '0;
    bit               m_known = 0;
    logic [DW-1:0]    m_mem [int];

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int off = 0; off < N; off++)
            if (v[(p + off) % N]) return (p + off) % N;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wptr  = 0;
            m_rptr  = 0;
            m_rsp   = '0;
            m_known = 0;
        end else begin
            int gw, gr, a;
            gw = pick(wr_valid, m_wptr);
            gr = pick(rd_valid, m_rptr);
            m_rsp.valid = (gr >= 0);
            if (gr >= 0) begin
                a         = int'(rd_addr[gr*AW +: AW]);
                m_known   = m_mem.exists(a);
                m_rsp.id  = MAX_ID_W'(gr);
                m_rsp.data = m_known ? MAX_DATA_W'(m_mem[a]) : '0;
                m_rptr    = (gr + 1) % N;
            end
            if (gw >= 0) begin
                m_mem[int'(wr_addr[gw*AW +: AW])] = wr_data[gw*DW +: DW];
                m_wptr = (gw + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] ew, er;
        int gw, gr;
        ew = '0;
        er = '0;
        if (!rst) begin
            gw = pick(wr_valid, m_wptr);
            gr = pick(rd_valid, m_rptr);
            if (gw >= 0) ew[gw] = 1'b1;
            if (gr >= 0) er[gr] = 1'b1;
        end
        chk("model_wr_ready", wr_ready, ew);
        chk("model_rd_ready", rd_ready, er);
        chk("model_rsp_valid", rsp_valid, m_rsp.valid && !rst);
        if (!rst && m_rsp.valid) begin
            chk("model_rsp_id", rsp_id, m_rsp.id);
            if (m_known) chk("model_rsp_data", rsp_data, m_rsp.data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid[k]        = 1'b1;
        wr_addr[k*AW +: AW] = a;
        wr_data[k*DW +: DW] = d;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_valid[k]         = 1'b1;
        rd_addr[k*AW +: AW] = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr_valid = '0; wr_addr = '0; wr_data = '0;
        rd_valid = '0; rd_addr = '0;
        repeat (2) cyc();
        rd_valid = 4'hF;
        wr_valid = 4'hF;
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rd_ready", rd_ready, 0);
        chk("reset_wr_ready", wr_ready, 0);
        cyc();
        rst = 1'b0;
        rd_valid = '0;
        wr_valid = '0;

        // Basic write then read by another requester.
        set_wr(1, 10'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("basic_wr_ready", wr_ready, 4'b0010);
        cyc();
        wr_valid = '0;
        set_rd(2, 10'd5);
        @(negedge clk);
        chk("basic_rd_ready", rd_ready, 4'b0100);
        cyc();
        rd_valid = '0;
        @(negedge clk);
        chk("basic_rsp_valid", rsp_valid, 1);
        chk("basic_rsp_id", rsp_id, 2);
        chk("basic_rsp_data", rsp_data, 32'hDEADBEEF);

        // Round-robin from reset with all readers active.
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < N; k++) set_rd(k, 10'd5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_grant", rd_ready, 4'b0001 << (i % 4));
            if (i > 0) begin
                chk("rr_rsp_valid", rsp_valid, 1);
                chk("rr_rsp_id", rsp_id, (i - 1) % 4);
            end
            cyc();
        end
        rd_valid = '0;
        @(negedge clk);
        chk("rr_last_rsp_id", rsp_id, 3);
        chk("rr_last_rsp_valid", rsp_valid, 1);
        cyc();
        @(negedge clk);
        chk("rr_after_valid", rsp_valid, 0);

        // Pointer skip: grant req1 so pointer sits at 2, then only 0 and 3 compete.
        cyc();
        set_rd(1, 10'd5);
        @(negedge clk);
        chk("skip_prime", rd_ready, 4'b0010);
        cyc();
        rd_valid = '0;
        set_rd(0, 10'd5);
        set_rd(3, 10'd5);
        @(negedge clk);
        chk("skip_first", rd_ready, 4'b1000);
        cyc();
        @(negedge clk);
        chk("skip_second", rd_ready, 4'b0001);
        cyc();
        rd_valid = '0;

        // Read-first collision at address 9.
        set_wr(0, 10'd9, 32'h11);
        @(negedge clk);
        cyc();
        set_wr(0, 10'd9, 32'h22);
        set_rd(1, 10'd9);
        @(negedge clk);
        chk("coll_both_wr", wr_ready, 4'b0001);
        chk("coll_both_rd", rd_ready, 4'b0010);
        cyc();
        wr_valid = '0;
        @(negedge clk);
        chk("coll_old_data", rsp_data, 32'h11);
        cyc();
        rd_valid = '0;
        @(negedge clk);
        chk("coll_new_data", rsp_data, 32'h22);

        // Reset while a response is in flight.
        cyc();
        set_rd(2, 10'd5);
        @(negedge clk);
        chk("mid_rst_grant", rd_ready, 4'b0100);
        cyc();
        rd_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        cyc();
        set_rd(1, 10'd5);
        set_rd(3, 10'd9);
        @(negedge clk);
        chk("mid_rst_ignored", rd_ready, 4'b0000);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_lowest", rd_ready, 4'b0010);
        cyc();
        rd_valid = '0;
        @(negedge clk);
        chk("post_rst_rsp_id", rsp_id, 1);
        chk("post_rst_rsp_data", rsp_data, 32'hDEADBEEF);

        // Idle stretch, then confirm contents survived.
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge clk);
            chk("idle_wr_ready", wr_ready, 0);
            chk("idle_rd_ready", rd_ready, 0);
            chk("idle_rsp_valid", rsp_valid, 0);
        end
        cyc();
        set_rd(0, 10'd5);
        cyc();
        rd_valid = '0;
        set_rd(3, 10'd9);
        @(negedge clk);
        chk("idle_keep_5", rsp_data, 32'hDEADBEEF);
        cyc();
        rd_valid = '0;
        @(negedge clk);
        chk("idle_keep_9", rsp_data, 32'h22);
        chk("idle_keep_9_id", rsp_id, 3);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sdp_ram_arbiter.md
Name: sdp_ram_arbiter

Overview:
- Shares one simple dual-port block RAM among NUM_REQ requesters.
- Independent round-robin arbiters for the write port and the read port.
- Tracks the RAM's 1-cycle registered-read latency and returns each read response tagged with the requester index.
- Sits between multiple producer/consumer engines and a single sdp_block_ram instance, which lives inside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 10, RAM address width in bits.
- DATA_WIDTH, 32, RAM data width in bits.

Ports:
- i_clk  input  1  clock; all logic is rising-edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_wr_valid  input  NUM_REQ  per-requester write request.
- i_wr_addr  input  NUM_REQ*ADDR_WIDTH  packed write addresses; requester n at slice n.
- i_wr_data  input  NUM_REQ*DATA_WIDTH  packed write data.
- o_wr_ready  output  NUM_REQ  one-hot write grant.
- i_rd_valid  input  NUM_REQ  per-requester read request.
- i_rd_addr  input  NUM_REQ*ADDR_WIDTH  packed read addresses.
- o_rd_ready  output  NUM_REQ  one-hot read grant.
- o_rsp_valid  output  1  read data valid.
- o_rsp_id  output  $clog2(NUM_REQ)  requester index owning the response.
- o_rsp_data  output  DATA_WIDTH  read data.

Behaviour:
- Reset: o_rsp_valid=0, o_rsp_id=0, wr_ptr=0, rd_ptr=0, o_wr_ready/o_rd_ready=0 (all valids are ignored during reset). RAM contents are not cleared by reset.
- Grant rule:
  - Combinational grant within the cycle.
  - Search starts at the pointer and wraps modulo NUM_REQ; the first asserted valid wins.
  - ready is asserted only to the winner, and never without a matching valid.
  - A transfer occurs on valid&&ready at the rising edge.
- Pointer update: after a grant to index k, the pointer becomes (k+1) mod NUM_REQ. With no grant, the pointer holds.
- Fairness: a continuously asserted requester is granted within NUM_REQ cycles.
- Write path:
  - The granted requester's addr/data drive the RAM write port.
  - RAM write enable = |o_wr_ready.
  - Write latency is 1 cycle (data is in RAM after the edge).
- Read path:
  - The granted requester's addr drives the RAM read address.
  - The issue pipeline registers valid and id.
  - o_rsp_valid=1 and o_rsp_id=k exactly 1 cycle after the grant edge; o_rsp_data = RAM output in that cycle.
  - Responses cannot be stalled; requesters must accept them.
  - Throughput is one read per cycle.
- No read grant: the RAM read address holds its last value and o_rsp_valid=0 next cycle. o_rsp_data is don't-care when o_rsp_valid=0.
- Same-cycle read and write to the same address (read-first): the read returns the OLD data. The new data is visible to a read granted on a later cycle. No forwarding.
- Write and read arbitration are fully independent; one requester may be granted on both ports in the same cycle.
- Valid dropped before grant: allowed; the pointer is unaffected.
- Reset mid-operation: an in-flight response is discarded (o_rsp_valid forced 0 asynchronously) and the pointers return to 0.
- Width rules: pointer and id are $clog2(NUM_REQ) bits. With non-power-of-2 NUM_REQ, the wrap is explicit (k==NUM_REQ-1 -> 0).

Decomposition:
- Package sdp_ram_arb_pkg holds:
  - the localparam function for id width;
  - the typedef for the response struct {valid, id, data}.
- Sub-module rr_arbiter:
  - Parameter N; ports i_clk, i_rst, i_req[N], o_grant[N], o_grant_idx.
  - Contains its own pointer register.
  - Instantiated twice (write, read).
- The sdp_block_ram is instantiated once inside sdp_ram_arbiter.

Test Plan:
- Write/read basic: NUM_REQ=4; req1 writes addr 5 = 0xDEADBEEF; next cycle req2 reads addr 5 -> o_rd_ready=4'b0100, then 1 cycle later o_rsp_valid=1, id=2, data=0xDEADBEEF.
- Round-robin: all 4 rd_valid held high for 8 cycles from reset -> grants to idx 0,1,2,3,0,1,2,3; rsp ids follow with 1-cycle lag; o_rsp_valid high 8 consecutive cycles.
- Pointer skip: pointer=2 (after grant to 1); only req0 and req3 valid -> req3 granted first, then req0.
- Read-first collision: addr 9 holds 0x11; same cycle write 0x22 by req0 and read by req1 at addr 9 -> response 0x11; re-read next cycle -> 0x22.
- Reset mid-read: grant read at cycle t, assert i_rst during cycle t+1 before the edge -> o_rsp_valid=0 immediately; after release, first grant goes to the lowest-index valid requester.
- Idle: no valids for 10 cycles -> o_wr_ready=o_rd_ready=0, o_rsp_valid=0, RAM contents unchanged on subsequent reads.
